// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer: game, direction and execution
// states plus the one-hot button codes seen on direction_in.
package snake_pkg;

  typedef enum logic [1:0] {
    GAME_INIT  = 2'd0,
    GAME_RUN   = 2'd1,
    GAME_STOP  = 2'd2,
    GAME_PAUSE = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    EXEC_UPDATE     = 3'd0,
    EXEC_CHECK      = 3'd1,
    EXEC_INPUT      = 3'd2,
    EXEC_WAIT_LOGIC = 3'd3,
    EXEC_DISPLAY    = 3'd4
  } exec_state_e;

  localparam logic [3:0] BTN_UP    = 4'b0001;
  localparam logic [3:0] BTN_DOWN  = 4'b0010;
  localparam logic [3:0] BTN_LEFT  = 4'b0100;
  localparam logic [3:0] BTN_RIGHT = 4'b1000;

  function automatic logic btn_is_valid(input logic [3:0] btn);
    return (btn == BTN_UP) || (btn == BTN_DOWN) || (btn == BTN_LEFT) || (btn == BTN_RIGHT);
  endfunction

  function automatic dir_e btn_to_dir(input logic [3:0] btn);
    dir_e d;
    case (btn)
      BTN_DOWN:  d = DIR_DOWN;
      BTN_LEFT:  d = DIR_LEFT;
      BTN_RIGHT: d = DIR_RIGHT;
      default:   d = DIR_UP;
    endcase
    return d;
  endfunction

  function automatic dir_e dir_opposite(input dir_e d);
    dir_e o;
    case (d)
      DIR_UP:   o = DIR_DOWN;
      DIR_DOWN: o = DIR_UP;
      DIR_LEFT: o = DIR_RIGHT;
      default:  o = DIR_LEFT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dir_queue.sv
// Circular FIFO of buffered direction presses. A press is rejected when it
// repeats or reverses the most recent direction (queue tail, or current heading).
module dir_queue
  import snake_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_press_valid,
  input  dir_e       i_press_dir,
  input  logic       i_accept_en,
  input  dir_e       i_cur_dir,
  input  logic       i_pop,
  output dir_e       o_head,
  output logic [2:0] o_count
);

  localparam logic [1:0] LAST = 2'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);

  dir_e       r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;

  logic [1:0] w_tail_ptr;
  dir_e       w_ref;
  logic       w_push;
  logic       w_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_tail_ptr = (r_wr_ptr == 2'd0) ? LAST : r_wr_ptr - 2'd1;
  // Reference is taken before any same-cycle pop, so the check sees the pre-pop tail.
  assign w_ref  = (r_count != 3'd0) ? r_mem[w_tail_ptr] : i_cur_dir;
  assign w_push = i_press_valid && i_accept_en && (r_count != FULL) &&
                  (i_press_dir != w_ref) && (i_press_dir != dir_opposite(w_ref));
  assign w_pop  = i_pop && (r_count != 3'd0);

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      for (int i = 0; i < 4; i++) r_mem[i] <= DIR_UP;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_press_dir;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Snake game sequencer: per-tick execution FSM, game/direction state, watchdog
// on the datapath handshake, and row-scanned LED matrix drive.
module game_sequencer
  import snake_pkg::*;
#(
  parameter int ROWS            = 8,
  parameter int COLS            = 8,
  parameter int REFRESH_CYCLES  = 4,
  parameter int DIR_QUEUE_DEPTH = 2,
  parameter int LOGIC_TIMEOUT   = 255
) (
  input  logic                 clka,
  input  logic                 restart_n,
  input  logic [3:0]           direction_in,
  input  logic                 pause_in,
  input  logic                 logic_done,
  input  logic                 game_end,
  input  logic [ROWS*COLS-1:0] led_array,
  output logic [1:0]           game_state,
  output logic [1:0]           direction_state,
  output logic [2:0]           execution_state,
  output logic                 logic_tick,
  output logic                 no_update,
  output logic [ROWS-1:0]      row_cathode,
  output logic [COLS-1:0]      column_anode,
  output logic [2:0]           queue_count,
  output logic                 logic_timeout
);

  localparam logic [3:0]  ROW_LAST   = 4'(ROWS - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(REFRESH_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST  = 16'(LOGIC_TIMEOUT - 1);

  exec_state_e r_exec;
  exec_state_e w_exec_next;
  game_state_e r_game;
  dir_e        r_dir;
  logic [15:0] r_wait_cnt;
  logic [3:0]  r_row;
  logic [7:0]  r_frame;
  logic        r_end_flag;
  logic        r_pause_req;
  logic        r_timeout;
  logic        r_pause_prev;
  logic [3:0]  r_btn_prev;

  logic        w_press_valid;
  logic        w_pause_rise;
  logic        w_wait_expire;
  logic        w_display_done;
  logic        w_accept_en;
  dir_e        w_q_head;
  logic [2:0]  w_q_count;

  assign w_press_valid  = (direction_in != r_btn_prev) && btn_is_valid(direction_in);
  assign w_pause_rise   = pause_in && !r_pause_prev;
  assign w_accept_en    = (r_game == GAME_INIT) || (r_game == GAME_RUN);
  assign w_wait_expire  = (r_exec == EXEC_WAIT_LOGIC) && !logic_done && (r_wait_cnt == WAIT_LAST);
  assign w_display_done = (r_row == ROW_LAST) && (r_frame == FRAME_LAST);

  dir_queue #(.DEPTH(DIR_QUEUE_DEPTH)) u_dir_queue (
    .i_clk         (clka),
    .i_rst_n       (restart_n),
    .i_press_valid (w_press_valid),
    .i_press_dir   (btn_to_dir(direction_in)),
    .i_accept_en   (w_accept_en),
    .i_cur_dir     (r_dir),
    .i_pop         (r_exec == EXEC_INPUT),
    .o_head        (w_q_head),
    .o_count       (w_q_count)
  );

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) r_exec <= EXEC_UPDATE;
    else            r_exec <= w_exec_next;
  end

  // CHECK sees the game state already updated by the preceding UPDATE.
  always_comb begin
    w_exec_next = r_exec;
    case (r_exec)
      EXEC_UPDATE:     w_exec_next = EXEC_CHECK;
      EXEC_CHECK:      w_exec_next = ((r_game == GAME_INIT) || (r_game == GAME_PAUSE)) ?
                                     EXEC_DISPLAY : EXEC_INPUT;
      EXEC_INPUT:      w_exec_next = EXEC_WAIT_LOGIC;
      EXEC_WAIT_LOGIC: if (logic_done || w_wait_expire) w_exec_next = EXEC_DISPLAY;
      EXEC_DISPLAY:    if (w_display_done) w_exec_next = EXEC_UPDATE;
      default:         w_exec_next = EXEC_UPDATE;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_game       <= GAME_INIT;
      r_dir        <= DIR_RIGHT;
      r_end_flag   <= 1'b0;
      r_pause_req  <= 1'b0;
      r_timeout    <= 1'b0;
      r_pause_prev <= 1'b0;
      r_btn_prev   <= 4'd0;
    end else begin
      r_pause_prev <= pause_in;
      r_btn_prev   <= direction_in;
      if (w_pause_rise)                r_pause_req <= 1'b1;
      else if (r_exec == EXEC_UPDATE)  r_pause_req <= 1'b0;
      if (r_exec == EXEC_UPDATE) begin
        r_end_flag <= 1'b0;
        case (r_game)
          GAME_INIT:  if (w_q_count != 3'd0) r_game <= GAME_RUN;
          GAME_RUN:   if (r_end_flag) r_game <= GAME_STOP;
                      else if (r_pause_req) r_game <= GAME_PAUSE;
          GAME_PAUSE: if (r_pause_req) r_game <= GAME_RUN;
          default:    r_game <= r_game;
        endcase
      end else if ((r_exec == EXEC_WAIT_LOGIC) && logic_done && game_end) begin
        r_end_flag <= 1'b1;
      end
      if (w_wait_expire) r_timeout <= 1'b1;
      if ((r_exec == EXEC_INPUT) && (w_q_count != 3'd0)) r_dir <= w_q_head;
    end
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_wait_cnt <= 16'd0;
      r_row      <= 4'd0;
      r_frame    <= 8'd0;
    end else begin
      r_wait_cnt <= (r_exec == EXEC_WAIT_LOGIC) ? r_wait_cnt + 16'd1 : 16'd0;
      if (r_exec != EXEC_DISPLAY) begin
        r_row   <= 4'd0;
        r_frame <= 8'd0;
      end else if (r_row == ROW_LAST) begin
        r_row   <= 4'd0;
        r_frame <= (r_frame == FRAME_LAST) ? 8'd0 : r_frame + 8'd1;
      end else begin
        r_row <= r_row + 4'd1;
      end
    end
  end

  always_comb begin
    row_cathode  = '1;
    column_anode = '0;
    if (r_exec == EXEC_DISPLAY) begin
      for (int r = 0; r < ROWS; r++) begin
        if (r_row == 4'(r)) begin
          row_cathode[r] = 1'b0;
          column_anode   = led_array[r*COLS +: COLS];
        end
      end
    end
  end

  assign game_state      = r_game;
  assign direction_state = r_dir;
  assign execution_state = r_exec;
  assign logic_tick      = (r_exec == EXEC_INPUT);
  assign no_update       = (r_exec == EXEC_INPUT) && (r_game == GAME_STOP);
  assign queue_count     = w_q_count;
  assign logic_timeout   = r_timeout;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed corner sequences plus random stimulus, all
// cycles checked against a phase/queue-level model of the game rules.
module tb_game_sequencer;

  localparam int ROWS = 8, COLS = 8, REFRESH = 4, DEPTH = 2, TIMEOUT = 255;
  localparam int X_UPDATE = 0, X_CHECK = 1, X_INPUT = 2, X_WAIT = 3, X_DISPLAY = 4;
  localparam int G_INIT = 0, G_RUN = 1, G_STOP = 2, G_PAUSE = 3;

  logic        clka = 1'b0;
  logic        restart_n = 1'b1;
  logic [3:0]  direction_in = 4'd0;
  logic        pause_in = 1'b0;
  logic        logic_done = 1'b0;
  logic        game_end = 1'b0;
  logic [63:0] led_array = 64'd0;
  logic [1:0]  game_state, direction_state;
  logic [2:0]  execution_state, queue_count;
  logic        logic_tick, no_update, logic_timeout;
  logic [7:0]  row_cathode, column_anode;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  int   m_exec, m_game, m_dir, m_elapsed;
  int   m_q[$];
  bit   m_end, m_preq, m_tout, m_pprev;
  logic [3:0] m_dprev;

  typedef struct {
    logic [3:0] btn;
    logic [2:0] exp_count;
    string      name;
  } press_vec_t;
  press_vec_t tbl[5];

  // clock / reset
  always #5 clka = ~clka;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  game_sequencer #(
    .ROWS(ROWS), .COLS(COLS), .REFRESH_CYCLES(REFRESH),
    .DIR_QUEUE_DEPTH(DEPTH), .LOGIC_TIMEOUT(TIMEOUT)
  ) dut (
    .clka(clka), .restart_n(restart_n), .direction_in(direction_in),
    .pause_in(pause_in), .logic_done(logic_done), .game_end(game_end),
    .led_array(led_array), .game_state(game_state), .direction_state(direction_state),
    .execution_state(execution_state), .logic_tick(logic_tick), .no_update(no_update),
    .row_cathode(row_cathode), .column_anode(column_anode),
    .queue_count(queue_count), .logic_timeout(logic_timeout)
  );

  // reference model
  function automatic int btn_code(input logic [3:0] b);
    case (b)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_exec = X_UPDATE; m_game = G_INIT; m_dir = 3; m_elapsed = 0;
    m_q.delete();
    m_end = 0; m_preq = 0; m_tout = 0; m_pprev = 0; m_dprev = 4'd0;
  endtask

  task automatic model_clock();
    int  code, refd, n_exec, n_game, n_dir;
    bit  press, accept;
    code   = btn_code(direction_in);
    press  = (direction_in != m_dprev) && (code >= 0);
    refd   = (m_q.size() > 0) ? m_q[$] : m_dir;
    accept = press && (m_game == G_INIT || m_game == G_RUN) && (m_q.size() < DEPTH) &&
             (code != refd) && (code != (refd ^ 1));
    n_game = m_game;
    n_dir  = m_dir;
    if (m_exec == X_UPDATE) begin
      if (m_game == G_INIT && m_q.size() > 0) n_game = G_RUN;
      else if (m_game == G_RUN && m_end)      n_game = G_STOP;
      else if (m_game == G_RUN && m_preq)     n_game = G_PAUSE;
      else if (m_game == G_PAUSE && m_preq)   n_game = G_RUN;
    end
    if (m_exec == X_INPUT && m_q.size() > 0) n_dir = m_q.pop_front();
    if (accept) m_q.push_back(code);
    n_exec = m_exec;
    case (m_exec)
      X_UPDATE: n_exec = X_CHECK;
      X_CHECK:  n_exec = (m_game == G_INIT || m_game == G_PAUSE) ? X_DISPLAY : X_INPUT;
      X_INPUT:  n_exec = X_WAIT;
      X_WAIT: begin
        if (logic_done) n_exec = X_DISPLAY;
        else if (m_elapsed == TIMEOUT - 1) begin n_exec = X_DISPLAY; m_tout = 1; end
      end
      default: if (m_elapsed == ROWS * REFRESH - 1) n_exec = X_UPDATE;
    endcase
    if (m_exec == X_UPDATE) m_end = 0;
    else if (m_exec == X_WAIT && logic_done && game_end) m_end = 1;
    if (pause_in && !m_pprev) m_preq = 1;
    else if (m_exec == X_UPDATE) m_preq = 0;
    m_pprev   = pause_in;
    m_dprev   = direction_in;
    m_elapsed = (n_exec == m_exec) ? m_elapsed + 1 : 0;
    m_exec = n_exec; m_game = n_game; m_dir = n_dir;
  endtask

  function automatic logic [31:0] model_outputs();
    logic       tk, nu;
    logic [7:0] cath, anode;
    int         row;
    tk = (m_exec == X_INPUT);
    nu = tk && (m_game == G_STOP);
    cath = 8'hFF; anode = 8'h00;
    if (m_exec == X_DISPLAY) begin
      row   = m_elapsed % ROWS;
      cath  = ~(8'h01 << row);
      anode = led_array[row*COLS +: COLS];
    end
    return {3'b0, 2'(m_game), 2'(m_dir), 3'(m_exec), tk, nu, cath, anode, 3'(m_q.size()), m_tout};
  endfunction

  function automatic logic [31:0] dut_outputs();
    return {3'b0, game_state, direction_state, execution_state, logic_tick, no_update,
            row_cathode, column_anode, queue_count, logic_timeout};
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clka);
    if (restart_n) model_clock();
    else           model_reset();
    #1;
    exp_q.push_back(model_outputs());
    check("cycle_outputs", dut_outputs(), exp_q.pop_front());
  endtask

  task automatic wait_exec(input int target, input int budget);
    int n = 0;
    while (int'(execution_state) != target && n < budget) begin
      tick();
      n++;
    end
    check("wait_exec", 32'(execution_state), 32'(target));
  endtask

  task automatic press(input logic [3:0] b);
    direction_in = b;
    tick();
    direction_in = 4'd0;
    tick();
  endtask

  task automatic pulse_reset();
    restart_n = 1'b0;
    tick();
    restart_n = 1'b1;
  endtask

  initial begin
    int n;
    tbl[0] = '{4'b0100, 3'd0, "left_reversal"};
    tbl[1] = '{4'b0001, 3'd1, "up_queued"};
    tbl[2] = '{4'b0010, 3'd1, "down_reversal"};
    tbl[3] = '{4'b0100, 3'd2, "left_queued"};
    tbl[4] = '{4'b0010, 3'd2, "full_drop"};
    led_array = {$urandom, $urandom};
    model_reset();

    // reset values
    #1 restart_n = 1'b0;
    #2;
    check("rst_exec", 32'(execution_state), 0);
    check("rst_game", 32'(game_state), G_INIT);
    check("rst_dir", 32'(direction_state), 3);
    check("rst_count", 32'(queue_count), 0);
    check("rst_cath", 32'(row_cathode), 32'hFF);
    check("rst_anode", 32'(column_anode), 0);
    check("rst_tick", 32'(logic_tick), 0);
    check("rst_noupd", 32'(no_update), 0);
    check("rst_tout", 32'(logic_timeout), 0);
    tick();
    restart_n = 1'b1;
    check("rel_exec", 32'(execution_state), X_UPDATE);

    // idle scan in INIT
    tick();
    check("idle_check", 32'(execution_state), X_CHECK);
    tick();
    for (int i = 0; i < ROWS * REFRESH; i++) begin
      check("idle_scan", 32'(row_cathode), 32'(8'hFF ^ (8'h01 << (i % ROWS))));
      tick();
    end
    check("idle_back_update", 32'(execution_state), X_UPDATE);
    check("idle_still_init", 32'(game_state), G_INIT);

    // first presses in INIT
    wait_exec(X_DISPLAY, 10);
    press(4'b1000);
    press(4'b0001);
    check("init_count", 32'(queue_count), 1);
    wait_exec(X_UPDATE, 64);
    tick();
    check("init_to_run", 32'(game_state), G_RUN);
    tick();
    check("input_tick", 32'(logic_tick), 1);
    check("input_dir_before", 32'(direction_state), 3);
    tick();
    check("dir_after_pop", 32'(direction_state), 0);
    check("tick_one_cycle", 32'(logic_tick), 0);

    // turn to RIGHT, then filter table
    press(4'b1000);
    check("queue_right", 32'(queue_count), 1);
    logic_done = 1'b1; tick(); logic_done = 1'b0;
    wait_exec(X_INPUT, 64);
    tick();
    check("facing_right", 32'(direction_state), 3);
    logic_done = 1'b1; tick(); logic_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press(tbl[i].btn);
      check(tbl[i].name, 32'(queue_count), 32'(tbl[i].exp_count));
    end

    // collision -> STOP
    wait_exec(X_INPUT, 64);
    tick();
    logic_done = 1'b1; game_end = 1'b1; tick(); logic_done = 1'b0; game_end = 1'b0;
    wait_exec(X_UPDATE, 64);
    tick();
    check("stop_state", 32'(game_state), G_STOP);
    tick();
    check("stop_tick", 32'(logic_tick), 1);
    check("stop_noupd", 32'(no_update), 1);
    tick();
    press(4'b0001);
    check("stop_ignore_press", 32'(queue_count), 0);

    // watchdog timeout, then pause/resume
    pulse_reset();
    wait_exec(X_DISPLAY, 5);
    press(4'b0001);
    wait_exec(X_UPDATE, 64);
    wait_exec(X_WAIT, 5);
    n = 0;
    while (int'(execution_state) == X_WAIT && n < 400) begin
      tick();
      n++;
    end
    check("wait_len", 32'(n), TIMEOUT);
    check("tout_display", 32'(execution_state), X_DISPLAY);
    check("tout_flag", 32'(logic_timeout), 1);
    pause_in = 1'b1; tick(); pause_in = 1'b0; tick();
    wait_exec(X_UPDATE, 64);
    tick();
    check("to_pause", 32'(game_state), G_PAUSE);
    tick();
    tick();
    check("pause_skips_input", 32'(execution_state), X_DISPLAY);
    pause_in = 1'b1; tick(); pause_in = 1'b0; tick();
    wait_exec(X_UPDATE, 64);
    tick();
    check("resume_run", 32'(game_state), G_RUN);
    check("tout_sticky", 32'(logic_timeout), 1);

    // reset asserted mid-scan
    wait_exec(X_DISPLAY, 400);
    tick(); tick(); tick();
    check("row3_cath", 32'(row_cathode), 32'hF7);
    restart_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_cath", 32'(row_cathode), 32'hFF);
    check("mid_rst_anode", 32'(column_anode), 0);
    check("mid_rst_exec", 32'(execution_state), X_UPDATE);
    check("mid_rst_game", 32'(game_state), G_INIT);
    check("mid_rst_dir", 32'(direction_state), 3);
    check("mid_rst_tout", 32'(logic_timeout), 0);
    tick();
    restart_n = 1'b1;
    check("post_rel_update", 32'(execution_state), X_UPDATE);
    tick();
    check("post_rel_check", 32'(execution_state), X_CHECK);

    // random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)      direction_in = 4'd0;
      else if (r < 8) direction_in = 4'(1 << $urandom_range(0, 3));
      else            direction_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) pause_in = ~pause_in;
      logic_done = ($urandom_range(0, 5) == 0);
      game_end   = ($urandom_range(0, 3) == 0);
      led_array  = {$urandom, $urandom};
      restart_n  = ($urandom_range(0, 599) != 0);
      tick();
    end
    restart_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
